// File: rtl/seq_pkg.sv
// seq_pkg: types and constants shared by the bit-pattern link blocks.
//   tx_state_t      : transmitter FSM states
//   DEFAULT_PAT_W   : default pattern length in bits
//   DEFAULT_PATTERN : default pattern, sent MSB-first
//   clog2_min1()    : counter width helper that never returns 0
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } tx_state_t;

   localparam int DEFAULT_PAT_W = 3;
   localparam logic [DEFAULT_PAT_W-1:0] DEFAULT_PATTERN = 3'b101;

   // Width of a counter that has to hold values 0..n-1. A counter is always
   // at least one bit wide, even when it only ever holds 0.
   function automatic int clog2_min1(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_gen_tx.sv
// seq_gen_tx: Moore-FSM serial pattern transmitter.
// Shifts PATTERN out MSB-first on dout, one bit per clock, 'reps' times,
// with GAP_CYCLES idle-bit cycles between repetitions.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous reset, active-high
//   start  in   transmission request, only looked at in IDLE
//   reps   in   repetition count, latched together with start
//   abort  in   cancel transmission, back to IDLE without a done pulse
//   dout   out  serial bit out (IDLE_BIT when not sending)
//   busy   out  high in SEND and GAP
//   done   out  one-cycle pulse after the last bit of the last repetition
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; dout=IDLE_BIT
// SEND  | shifting PATTERN[PAT_W-1-bit_idx] out; busy=1
// GAP   | idle bits between repetitions; busy=1
// DONE  | single-cycle done pulse, then IDLE
module seq_gen_tx
   import seq_pkg::*;
#(
   parameter int               PAT_W      = DEFAULT_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN    = DEFAULT_PATTERN,
   parameter logic             IDLE_BIT   = 1'b0,
   parameter int               GAP_CYCLES = 1,
   parameter int               CNT_W      = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] reps,
   input  logic             abort,
   output logic             dout,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = clog2_min1(PAT_W);
   localparam int GAP_W = clog2_min1(GAP_CYCLES + 1);

   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
   // With GAP_CYCLES==0 the GAP state is unreachable; keep the constant sane.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

   tx_state_t        state, state_nx;
   logic [BIT_W-1:0] bit_idx, bit_nx;
   logic [GAP_W-1:0] gap_cnt, gap_nx;
   logic [CNT_W-1:0] rep_cnt, rep_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_idx <= '0;
         gap_cnt <= '0;
         rep_cnt <= '0;
      end else begin
         state   <= state_nx;
         bit_idx <= bit_nx;
         gap_cnt <= gap_nx;
         rep_cnt <= rep_nx;
      end
   end

   // Next-state logic plus Moore output decode; outputs depend only on the
   // registered state and bit index, never on the inputs.
   always_comb begin
      state_nx = state;
      bit_nx   = bit_idx;
      gap_nx   = gap_cnt;
      rep_nx   = rep_cnt;
      dout     = IDLE_BIT;
      busy     = 1'b0;
      done     = 1'b0;

      case (state)
         IDLE: begin
            // abort outranks start: a simultaneous request is dropped
            if (!abort && start) begin
               if (reps != '0) begin
                  state_nx = SEND;
                  rep_nx   = reps;
                  bit_nx   = '0;
                  gap_nx   = '0;
               end else begin
                  state_nx = DONE;
               end
            end
         end

         SEND: begin
            dout = PATTERN[BIT_LAST - bit_idx];
            busy = 1'b1;
            if (bit_idx == BIT_LAST) begin
               bit_nx = '0;
               gap_nx = '0;
               rep_nx = rep_cnt - 1'b1;
               if (rep_cnt == REP_ONE) begin
                  state_nx = DONE;
               end else if (GAP_CYCLES > 0) begin
                  state_nx = GAP;
               end
               // otherwise stay in SEND: back-to-back repetition
            end else begin
               bit_nx = bit_idx + 1'b1;
            end
         end

         GAP: begin
            busy = 1'b1;
            if (gap_cnt == GAP_LAST) begin
               state_nx = SEND;
               bit_nx   = '0;
               gap_nx   = '0;
            end else begin
               gap_nx = gap_cnt + 1'b1;
            end
         end

         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
            bit_nx   = '0;
            gap_nx   = '0;
            rep_nx   = '0;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase

      if (abort && (state != IDLE)) begin
         state_nx = IDLE;
         bit_nx   = '0;
         gap_nx   = '0;
         rep_nx   = '0;
      end
   end

endmodule
